// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared DSP stream types, constants and helpers
package dsp_pkg;

  // Signed mixer product / decimated sample
  typedef logic signed [31:0] sample_t;

  // Output register occupancy
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  localparam logic [3:0] STRB_ALL = 4'hF;

  // Accumulator width that cannot overflow for a full window of 32-bit samples
  function automatic int acc_width(input int decimation);
    return 32 + $clog2(decimation);
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// rtl/axis_out_reg.sv - single-entry stream output holding register
module axis_out_reg
  import dsp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             tready,
  output logic             tvalid,
  output logic [WIDTH-1:0] tdata,
  output logic             tlast
);

  out_state_t state;

  // A load always wins: it may coincide with the drain of the previous beat,
  // which gives back-to-back outputs without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OUT_EMPTY;
      tdata <= '0;
      tlast <= 1'b0;
    end else if (load) begin
      state <= OUT_FULL;
      tdata <= load_data;
      tlast <= load_last;
    end else if (state == OUT_FULL && tready) begin
      state <= OUT_EMPTY;
    end
  end

  assign tvalid = (state == OUT_FULL);

endmodule

// File: rtl/boxcar_decimator.sv
// rtl/boxcar_decimator.sv - integrate-and-dump decimator for one I/Q branch
module boxcar_decimator
  import dsp_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int DECIMATION             = 16,
  parameter int SHIFT                  = $clog2(DECIMATION)
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [3:0]                          s00_axis_tstrb,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic                                m00_axis_tlast,
  output logic [3:0]                          m00_axis_tstrb
);

  localparam int ACC_W = acc_width(DECIMATION);
  localparam int CNT_W = $clog2(DECIMATION);
  localparam int EXT_W = ACC_W - C_S00_AXIS_TDATA_WIDTH;

  logic [CNT_W-1:0]                   cnt;
  logic signed [ACC_W-1:0]            acc;
  logic signed [ACC_W-1:0]            sample_ext;
  logic signed [ACC_W-1:0]            acc_next;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]  dump_data;
  logic                               accept;
  logic                               dump;
  logic                               unused_tstrb;

  // Byte strobes carry no meaning for a sample stream
  assign unused_tstrb = ^s00_axis_tstrb;

  // Input is held off only while an undelivered output blocks the register
  assign s00_axis_tready = s00_axis_aresetn && !(m00_axis_tvalid && !m00_axis_tready);
  assign accept          = s00_axis_tvalid && s00_axis_tready;

  // Window sum: the first beat of a window replaces the stale sum
  always_comb begin
    sample_ext = {{EXT_W{s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1]}}, s00_axis_tdata};
    acc_next   = (cnt == '0) ? sample_ext : acc + sample_ext;
    dump       = accept && ((cnt == CNT_W'(DECIMATION - 1)) || s00_axis_tlast);
    dump_data  = C_M00_AXIS_TDATA_WIDTH'(acc_next >>> SHIFT);
  end

  // Counter and accumulator advance only on accepted beats
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      acc <= acc_next;
      cnt <= dump ? '0 : cnt + 1'b1;
    end
  end

  axis_out_reg #(
    .WIDTH(C_M00_AXIS_TDATA_WIDTH)
  ) u_out_reg (
    .clk       (s00_axis_aclk),
    .rst_n     (s00_axis_aresetn),
    .load      (dump),
    .load_data (dump_data),
    .load_last (s00_axis_tlast),
    .tready    (m00_axis_tready),
    .tvalid    (m00_axis_tvalid),
    .tdata     (m00_axis_tdata),
    .tlast     (m00_axis_tlast)
  );

  assign m00_axis_tstrb = STRB_ALL;

endmodule

// File: tb/tb_boxcar_decimator.sv
// tb/tb_boxcar_decimator.sv - self-checking bench for boxcar_decimator
module tb_boxcar_decimator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tlast;
  logic        s_tready;
  logic        m_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [3:0]  m_tstrb;

  always #5 clk = ~clk;

  boxcar_decimator #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32),
    .DECIMATION(4),
    .SHIFT(2)
  ) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tready  (s_tready),
    .m00_axis_tready  (m_tready),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tlast   (m_tlast),
    .m00_axis_tstrb   (m_tstrb)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] out_d[$];
  logic        out_l[$];
  logic [31:0] exp_d[$];
  logic        exp_l[$];
  longint      ws;
  int          wn;
  bit          rnd_done;

  typedef struct {
    logic [3:0][31:0] d;
    logic [3:0]       l;
    int               n;
    logic [31:0]      ed;
    logic             el;
  } vec_t;

  vec_t tab[6];

  // Output monitor: a beat is delivered when valid and ready meet at an edge
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      out_d.push_back(m_tdata);
      out_l.push_back(m_tlast);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] floor4(input longint s);
    longint q;
    q = s / 4;
    if ((s % 4) != 0 && s < 0) q = q - 1;
    return q[31:0];
  endfunction

  // Reference: average each window (full or closed by tlast) over 4, rounding down
  task automatic model_push(input logic [31:0] d, input logic l);
    ws = ws + longint'($signed(d));
    wn++;
    if (wn == 4 || l) begin
      exp_d.push_back(floor4(ws));
      exp_l.push_back(l);
      ws = 0;
      wn = 0;
    end
  endtask

  task automatic model_clear();
    ws = 0;
    wn = 0;
    exp_d.delete();
    exp_l.delete();
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (ok) model_push(d, l);
    else begin
      total++;
      bad++;
      $display("FAIL send_timeout: input not accepted, data %h", d);
    end
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 100 && out_d.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    chk("wait_out", 32'(out_d.size() >= n), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] got(input int i);
    return (i < out_d.size()) ? out_d[i] : 32'hxxxxxxxx;
  endfunction

  initial begin
    logic [31:0] d;
    logic        l;

    tab[0] = '{d: {32'd400, 32'd300, 32'd200, 32'd100}, l: 4'b0000, n: 4, ed: 32'd250, el: 1'b0};
    tab[1] = '{d: {32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, l: 4'b0000, n: 4, ed: 32'hFFFFFFFE, el: 1'b0};
    tab[2] = '{d: {32'd0, 32'd0, 32'd8, 32'd8}, l: 4'b0010, n: 2, ed: 32'd4, el: 1'b1};
    tab[3] = '{d: {32'd12, 32'd12, 32'd12, 32'd12}, l: 4'b0000, n: 4, ed: 32'd12, el: 1'b0};
    tab[4] = '{d: {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}, l: 4'b0000, n: 4, ed: 32'h7FFFFFFF, el: 1'b0};
    tab[5] = '{d: {32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000}, l: 4'b0000, n: 4, ed: 32'h80000000, el: 1'b0};

    rst_n    = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 32'd0;
    s_tstrb  = 4'hF;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    model_clear();

    // Reset state
    #2;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata", m_tdata, 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_m_tstrb", 32'(m_tstrb), 32'hF);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    s_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_s_tready", 32'(s_tready), 32'd1);

    // Table-driven windows
    for (int k = 0; k < 6; k++) begin
      out_d.delete();
      out_l.delete();
      for (int j = 0; j < tab[k].n; j++) send(tab[k].d[j], tab[k].l[j]);
      chk($sformatf("t%0d_valid_next_cycle", k), 32'(m_tvalid), 32'd1);
      wait_out(1);
      idle(3);
      chk($sformatf("t%0d_count", k), 32'(out_d.size()), 32'd1);
      chk($sformatf("t%0d_data", k), got(0), tab[k].ed);
      chk($sformatf("t%0d_last", k), 32'((out_l.size() > 0) ? out_l[0] : 1'bx), 32'(tab[k].el));
    end

    // Backpressure: first output held, input stalled, then both drain
    out_d.delete();
    out_l.delete();
    m_tready = 1'b0;
    repeat (4) send(32'd5, 1'b0);
    chk("bp_first_valid", 32'(m_tvalid), 32'd1);
    chk("bp_first_data", m_tdata, 32'd5);
    fork
      begin
        repeat (4) send(32'd7, 1'b0);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_stalled", 32'(s_tready), 32'd0);
          chk("bp_hold_data", m_tdata, 32'd5);
          chk("bp_hold_valid", 32'(m_tvalid), 32'd1);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    wait_out(2);
    idle(3);
    chk("bp_count", 32'(out_d.size()), 32'd2);
    chk("bp_out0", got(0), 32'd5);
    chk("bp_out1", got(1), 32'd7);

    // Reset mid-window discards the partial sum
    repeat (3) send(32'd1000, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_s_tready", 32'(s_tready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    out_d.delete();
    out_l.delete();
    repeat (4) send(32'd10, 1'b0);
    wait_out(1);
    idle(3);
    chk("midrst_count", 32'(out_d.size()), 32'd1);
    chk("midrst_data", got(0), 32'd10);

    // Randomised stream with gaps, early closes and random backpressure
    model_clear();
    out_d.delete();
    out_l.delete();
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          case ($urandom_range(0, 4))
            0: d = 32'h7FFFFFFF;
            1: d = 32'h80000000;
            2: d = 32'($signed($urandom_range(0, 200)) - 100);
            default: d = $urandom;
          endcase
          l = ($urandom_range(0, 9) == 0);
          send(d, l);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          m_tready = ($urandom_range(0, 2) != 0);
        end
        m_tready = 1'b1;
      end
    join
    idle(10);
    chk("rnd_count", 32'(out_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      chk($sformatf("rnd_data_%0d", i), got(i), exp_d[i]);
      chk($sformatf("rnd_last_%0d", i), 32'((i < out_l.size()) ? out_l[i] : 1'bx), 32'(exp_l[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
